// File: rtl/ram_block_mover.sv
// rtl/ram_block_mover.sv - FILL/COPY bus-master sequencer for a single-port RAM
//
// Executes one command at a time against a single-port RAM with registered read data:
//   FILL: write fill_val to length words starting at dst_addr
//   COPY: read length words from src_addr and write them to dst_addr,
//         one word at a time (RD -> LAT -> WR)
// The block also keeps a running checksum of every word written by the current command.
//
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   start             command strobe, sampled only in IDLE
//   mode              0 = COPY, 1 = FILL
//   src_addr          COPY source start address
//   dst_addr          destination start address
//   length            word count; 0 = no-op; values above 2**ADDR_W are clamped
//   fill_val          FILL data
//   busy, done        status: command in progress / one-cycle completion pulse
//   checksum          sum of the words written by the last command
//   m_cen, m_wen      RAM chip enable and write enable
//   m_addr, m_dout    RAM address and write data
//   m_din             RAM registered read data
module ram_block_mover #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              m_cen,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic              fill_mode;
    logic [DATA_W-1:0] fill_r;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W-1:0] src_next;
    logic [ADDR_W-1:0] dst_next;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign src_next    = src_ptr + ADDR_ONE;
    assign dst_next    = dst_ptr + ADDR_ONE;

    // Every RAM-side output is loaded on the edge that enters the state it
    // belongs to, so the bus pins come straight from flops. m_dout doubles as
    // the read-data register for COPY: it captures m_din at the end of LAT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
            m_cen     <= 1'b0;
            m_wen     <= 1'b0;
            m_addr    <= '0;
            m_dout    <= '0;
            fill_mode <= 1'b0;
            fill_r    <= '0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done  <= 1'b0;
                    m_cen <= 1'b0;
                    if (start) begin
                        fill_mode <= mode;
                        fill_r    <= fill_val;
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len_clamped;
                        checksum  <= '0;
                        if (len_clamped == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (mode) begin
                            state  <= S_WR;
                            busy   <= 1'b1;
                            m_cen  <= 1'b1;
                            m_wen  <= 1'b1;
                            m_addr <= dst_addr;
                            m_dout <= fill_val;
                        end else begin
                            state  <= S_RD;
                            busy   <= 1'b1;
                            m_cen  <= 1'b1;
                            m_wen  <= 1'b0;
                            m_addr <= src_addr;
                        end
                    end
                end

                S_RD: begin
                    state <= S_LAT;
                    m_cen <= 1'b0;
                    m_wen <= 1'b0;
                end

                S_LAT: begin
                    // RAM read data is valid during LAT, one cycle after the RD issue.
                    state  <= S_WR;
                    m_cen  <= 1'b1;
                    m_wen  <= 1'b1;
                    m_addr <= dst_ptr;
                    m_dout <= m_din;
                end

                S_WR: begin
                    checksum  <= checksum + m_dout;
                    dst_ptr   <= dst_next;
                    src_ptr   <= src_next;
                    remaining <= remaining - REM_ONE;
                    if (remaining == REM_ONE) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        m_cen <= 1'b0;
                        m_wen <= 1'b0;
                    end else if (fill_mode) begin
                        state  <= S_WR;
                        m_addr <= dst_next;
                        m_dout <= fill_r;
                    end else begin
                        state  <= S_RD;
                        m_wen  <= 1'b0;
                        m_addr <= src_next;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    m_cen <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    m_cen <= 1'b0;
                    m_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_block_mover.sv
// tb/tb_ram_block_mover.sv - self-checking bench for ram_block_mover
module tb_ram_block_mover;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   length = '0;
    logic [DW-1:0] fill_val = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic          m_cen;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] m_din;

    int passed = 0;
    int total = 0;

    ram_block_mover #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_val(fill_val),
        .busy(busy), .done(done), .checksum(checksum),
        .m_cen(m_cen), .m_wen(m_wen), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read data and a backdoor load port.
    logic [DW-1:0] ram [WORDS];
    logic [DW-1:0] ram_dout = '0;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    int            wq[$];

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (m_cen) begin
            if (m_wen) begin
                ram[m_addr] <= m_dout;
                wq.push_back(int'(m_addr));
            end else begin
                ram_dout <= ram[m_addr];
            end
        end
    end
    assign m_din = ram_dout;

    // Reference model: memory image plus expected write-address list.
    logic [DW-1:0] ref_mem [WORDS];
    int            exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int clamp_len(input int len);
        return (len > WORDS) ? WORDS : len;
    endfunction

    // Forward word-by-word semantics: overlapping copies see earlier writes.
    task automatic model_run(input bit fill, input int src, input int dst, input int n,
                             input logic [DW-1:0] fv, output logic [DW-1:0] sum);
        logic [DW-1:0] v;
        sum = '0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            v = fill ? fv : ref_mem[(src + i) % WORDS];
            ref_mem[(dst + i) % WORDS] = v;
            sum = sum + v;
            exp_q.push_back((dst + i) % WORDS);
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < WORDS; i++) if (ram[i] !== ref_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_cmd(input bit fill, input int src, input int dst, input int len,
                           input logic [DW-1:0] fv, input bit poke_busy, input bit poke_done);
        logic [DW-1:0] exp_sum;
        int n, exp_done, cyc;
        n = clamp_len(len);
        model_run(fill, src, dst, n, fv, exp_sum);
        exp_done = (n == 0) ? 1 : (fill ? n + 1 : 3 * n + 1);
        wq.delete();
        start = 1'b1; mode = fill; src_addr = AW'(src); dst_addr = AW'(dst);
        length = (AW + 1)'(len); fill_val = fv;
        @(negedge clk);
        cyc = 1;
        check("checksum_cleared", checksum, 0);
        while (!done && cyc < 200) begin
            start = poke_busy && (cyc == 2);
            mode = 1'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
            length = (AW + 1)'($urandom); fill_val = $urandom;
            check("busy_during_cmd", busy, 1);
            if (fill || ((cyc - 1) % 3 != 1)) begin
                check("cen_pattern", m_cen, 1);
                check("wen_pattern", m_wen, fill || ((cyc - 1) % 3 == 2));
            end else begin
                check("cen_pattern", m_cen, 0);
            end
            @(negedge clk);
            cyc++;
        end
        check("done_cycle", cyc, exp_done);
        check("done_busy", busy, 0);
        check("done_cen", m_cen, 0);
        check("checksum", checksum, exp_sum);
        start = poke_done;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        @(negedge clk);
        check("no_restart_busy", busy, 0);
        check("no_restart_cen", m_cen, 0);
        check("checksum_held", checksum, exp_sum);
        check("write_count", wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) check("write_addr", wq[i], exp_q[i]);
        check_mem("mem_image");
    endtask

    initial begin
        logic [DW-1:0] dummy;
        int cyc;

        // Reset state, then preload RAM and model through the backdoor.
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);
        check("rst_cen", m_cen, 0);
        check("rst_wen", m_wen, 0);
        check("rst_addr", m_addr, 0);
        check("rst_dout", m_dout, 0);
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            bd_we = 1'b1; bd_addr = AW'(i); bd_data = $urandom;
            ref_mem[i] = bd_data;
        end
        @(negedge clk);
        bd_we = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_cen", m_cen, 0);
        check("idle_busy", busy, 0);

        // Directed commands.
        run_cmd(1'b1, 0, 4, 3, 32'hA5A5_0001, 1'b0, 1'b0);
        run_cmd(1'b0, 4, 20, 3, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b1, 0, 30, 4, 32'd7, 1'b0, 1'b0);
        run_cmd(1'b1, 0, 9, 40, 32'h1234_5678, 1'b1, 1'b1);
        run_cmd(1'b0, 3, 17, 0, 32'h0, 1'b0, 1'b1);
        run_cmd(1'b0, 2, 5, 8, 32'h0, 1'b1, 1'b1);
        run_cmd(1'b0, 10, 8, 33, 32'h0, 1'b0, 1'b0);

        // Randomised commands.
        for (int k = 0; k < 24; k++) begin
            run_cmd(1'($urandom), int'($urandom_range(0, WORDS - 1)), int'($urandom_range(0, WORDS - 1)),
                    int'($urandom_range(0, 40)), $urandom, 1'($urandom), 1'($urandom));
        end

        // Abort a COPY of 8 words in cycle 5: only the first word has been written.
        wq.delete();
        start = 1'b1; mode = 1'b0; src_addr = 5'd11; dst_addr = 5'd25; length = 6'd8;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        #2 reset_n = 1'b0;
        #1;
        check("abort_cen", m_cen, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_checksum", checksum, 0);
        check("abort_addr", m_addr, 0);
        model_run(1'b0, 11, 25, 1, 32'h0, dummy);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        check("abort_write_count", wq.size(), 1);
        check_mem("abort_mem");
        run_cmd(1'b0, 25, 0, 6, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b1, 0, 1, 5, $urandom, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
